// File: rtl/usr_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : usr_reg_n
// Brief    : WIDTH-bit universal shift register (hold / shift right / shift
//            left / parallel load) with a counted-transfer busy/done tracker.
//            Optional macro USR_ROTATE_EN turns shifts into rotates when rot=1.
// Revision : 1.0 - initial release
// ============================================================================
module usr_reg_n #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in_msb,
   input  logic             ser_in_lsb,
   input  logic             rot,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_lsb,
   output logic             ser_out_msb,
   output logic             busy,
   output logic             done
);

   localparam int              c_CW   = $clog2(WIDTH) + 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_XFER = 1'b1;

   localparam logic [1:0] c_HOLD = 2'b00;
   localparam logic [1:0] c_SHR  = 2'b01;
   localparam logic [1:0] c_SHL  = 2'b10;
   localparam logic [1:0] c_LOAD = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic [c_CW-1:0]  r_cnt;
   logic [0:0]       r_state;
   logic             r_done;
   logic             w_msb_fill;
   logic             w_lsb_fill;

`ifdef USR_ROTATE_EN
   // Rotate feeds the bit falling off the opposite end back in.
   assign w_msb_fill = rot ? r_q[0]       : ser_in_msb;
   assign w_lsb_fill = rot ? r_q[WIDTH-1] : ser_in_lsb;
`else
   logic w_unused_rot;
   assign w_unused_rot = rot;
   assign w_msb_fill   = ser_in_msb;
   assign w_lsb_fill   = ser_in_lsb;
`endif

   always_comb begin
      w_q_next = r_q;
      case (mode)
         c_HOLD:  w_q_next = r_q;
         c_SHR:   w_q_next = {w_msb_fill, r_q[WIDTH-1:1]};
         c_SHL:   w_q_next = {r_q[WIDTH-2:0], w_lsb_fill};
         c_LOAD:  w_q_next = d;
         default: w_q_next = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q     <= RST_VAL;
         r_cnt   <= '0;
         r_state <= c_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (en) begin
            r_q <= w_q_next;
            case (mode)
               c_LOAD: begin
                  r_cnt   <= '0;
                  r_state <= c_XFER;
               end
               c_SHR, c_SHL: begin
                  // Idle shifts move data but are not part of a transfer.
                  if (r_state == c_XFER) begin
                     if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign q           = r_q;
   assign ser_out_lsb = r_q[0];
   assign ser_out_msb = r_q[WIDTH-1];
   assign busy        = (r_state == c_XFER);
   assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_usr_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_usr_reg_n
// Brief    : Self-checking bench for usr_reg_n (WIDTH=8, RST_VAL=8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usr_reg_n;

   localparam int         c_W   = 8;
   localparam logic [7:0] c_RST = 8'hA5;

   logic       clk = 1'b0;
   logic       reset, en, ser_in_msb, ser_in_lsb, rot;
   logic [1:0] mode;
   logic [7:0] d;
   logic [7:0] q;
   logic       ser_out_lsb, ser_out_msb, busy, done;

   int checks = 0;
   int errors = 0;

   usr_reg_n #(.WIDTH(c_W), .RST_VAL(c_RST)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .rot(rot),
      .q(q), .ser_out_lsb(ser_out_lsb), .ser_out_msb(ser_out_msb),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (en === 1'b1)
         assert (!$isunknown(mode)) else $error("FAIL mode_x: mode=%b while en=1", mode);
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [7:0] d;
      logic       smsb;
      logic       slsb;
      logic [7:0] eq;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t tbl[$];

   // Reference model: pending counts shifts still owed to the current transfer.
   logic [7:0] m_q;
   int         m_pending;
   logic       m_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] dd,
                       input logic smsb, input logic slsb, input logic ro);
      reset = r; en = e; mode = m; d = dd; ser_in_msb = smsb; ser_in_lsb = slsb; rot = ro;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [7:0] dd,
                      input logic smsb, input logic slsb, input logic [7:0] eq,
                      input logic eb, input logic ed);
      vec_t v;
      v.rst = r; v.en = e; v.mode = m; v.d = dd; v.smsb = smsb; v.slsb = slsb;
      v.eq = eq; v.eb = eb; v.ed = ed;
      tbl.push_back(v);
   endtask

   function automatic void model(input logic r, input logic e, input logic [1:0] m,
                                 input logic [7:0] dd, input logic smsb, input logic slsb,
                                 input logic ro);
      logic fill_hi, fill_lo;
      fill_hi = smsb;
      fill_lo = slsb;
`ifdef USR_ROTATE_EN
      if (ro) begin
         fill_hi = m_q[0];
         fill_lo = m_q[7];
      end
`endif
      if (r) begin
         m_q = c_RST; m_pending = 0; m_done = 1'b0;
         return;
      end
      m_done = 1'b0;
      if (!e) return;
      if (m == 2'b11) begin
         m_q = dd;
         m_pending = c_W;
      end else if (m != 2'b00) begin
         if (m == 2'b01) m_q = (m_q >> 1) | (8'(fill_hi) << 7);
         else            m_q = (m_q << 1) | 8'(fill_lo);
         if (m_pending > 0) begin
            m_pending--;
            if (m_pending == 0) m_done = 1'b1;
         end
      end
   endfunction

   initial begin
      int pulses;
      int pulse_at;
      logic [7:0] sr_exp [8];

      reset = 1'b1; en = 1'b0; mode = 2'b00; d = '0;
      ser_in_msb = 1'b0; ser_in_lsb = 1'b0; rot = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_q", q, c_RST);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);

      // Load then hold
      add(0,1,2'b11,8'h3C,0,0, 8'h3C,1,0);
      for (int i = 0; i < 3; i++) add(0,1,2'b00,8'h00,0,0, 8'h3C,1,0);
      // Serial out of 8'h96
      add(0,1,2'b11,8'h96,0,0, 8'h96,1,0);
      sr_exp = '{8'h4B, 8'h25, 8'h12, 8'h09, 8'h04, 8'h02, 8'h01, 8'h00};
      for (int i = 0; i < 8; i++) add(0,1,2'b01,8'h00,0,0, sr_exp[i], (i != 7), (i == 7));
      add(0,1,2'b00,8'h00,0,0, 8'h00,0,0);
      // Enable gating with a load request masked by en=0
      add(0,1,2'b11,8'h01,0,0, 8'h01,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h02,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h04,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h08,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h10,1,0);
      for (int i = 0; i < 5; i++) add(0,0,2'b11,8'hFF,1,1, 8'h10,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h20,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h40,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h80,1,0);
      add(0,1,2'b10,8'h00,0,0, 8'h00,0,1);
      add(0,0,2'b00,8'h00,0,0, 8'h00,0,0);
      // Reset aborts a transfer mid-stream
      add(0,1,2'b11,8'h3C,0,0, 8'h3C,1,0);
      add(0,1,2'b01,8'h00,1,0, 8'h9E,1,0);
      add(1,1,2'b01,8'h00,1,0, c_RST,0,0);
      add(0,1,2'b00,8'h00,0,0, c_RST,0,0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].smsb, tbl[i].slsb, 1'b0);
         chk($sformatf("tbl%0d_q", i), q, tbl[i].eq);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
         chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
         chk($sformatf("tbl%0d_sol", i), ser_out_lsb, tbl[i].eq[0]);
         chk($sformatf("tbl%0d_som", i), ser_out_msb, tbl[i].eq[7]);
      end

      // Restart: reload mid-transfer, only the post-reload transfer completes
      pulses = 0; pulse_at = -1;
      step(0,1,2'b11,8'hFF,0,0,0);
      for (int i = 0; i < 5; i++) begin
         step(0,1,2'b01,8'h00,0,0,0);
         if (done) pulses++;
      end
      step(0,1,2'b11,8'h0F,0,0,0);
      if (done) pulses++;
      for (int i = 0; i < 8; i++) begin
         step(0,1,(i[0] ? 2'b10 : 2'b01),8'h00,0,0,0);
         if (done) begin pulses++; pulse_at = i; end
      end
      chk("restart_pulses", pulses, 1);
      chk("restart_pulse_at", pulse_at, 7);
      chk("restart_busy", busy, 1'b0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(0,1,2'b10,8'h00,0,1,0);
         if (done || busy) pulses++;
      end
      chk("idle_shift_quiet", pulses, 0);

      // Rotate behaviour (or plain shifts when the feature is compiled out)
      step(0,1,2'b11,8'h81,0,0,1);
      step(0,1,2'b10,8'h00,0,0,1);
`ifdef USR_ROTATE_EN
      chk("rot_left", q, 8'h03);
`else
      chk("rot_left", q, 8'h02);
`endif
      step(0,1,2'b01,8'h00,0,0,1);
      step(0,1,2'b01,8'h00,0,0,1);
`ifdef USR_ROTATE_EN
      chk("rot_right", q, 8'hC0);
`else
      chk("rot_right", q, 8'h00);
`endif

      // Randomised run against the reference model
      step(1,0,2'b00,8'h00,0,0,0);
      m_q = c_RST; m_pending = 0; m_done = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         logic       r_r, r_e, r_sm, r_sl, r_ro;
         logic [1:0] r_m;
         logic [7:0] r_d;
         r_r  = ($urandom_range(0, 99) == 0);
         r_e  = ($urandom_range(0, 9) != 0);
         r_m  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_d  = 8'($urandom);
         r_sm = 1'($urandom);
         r_sl = 1'($urandom);
         r_ro = 1'($urandom);
         step(r_r, r_e, r_m, r_d, r_sm, r_sl, r_ro);
         model(r_r, r_e, r_m, r_d, r_sm, r_sl, r_ro);
         chk("rnd_q", q, m_q);
         chk("rnd_busy", busy, (m_pending > 0));
         chk("rnd_done", done, m_done);
         chk("rnd_serout", {ser_out_msb, ser_out_lsb}, {m_q[7], m_q[0]});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usr_reg_n.md
Name: usr_reg_n

Overview:
- Parametrised universal shift register. Generalises the single-bit D flip-flop to a WIDTH-bit register.
- Modes: hold, shift right, shift left, parallel load; each has a gated enable.
- Includes a shift-transfer counter that pulses done after WIDTH shifts following a load.
- Used as the building block for serial-to-parallel and parallel-to-serial links in lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RST_VAL, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- ser_in_msb  input  1  bit entering q[WIDTH-1] on shift right.
- ser_in_lsb  input  1  bit entering q[0] on shift left.
- rot  input  1  rotate select; see Optional Feature.
- q  output  WIDTH  register contents.
- ser_out_lsb  output  1  equals q[0], combinational from q.
- ser_out_msb  output  1  equals q[WIDTH-1], combinational from q.
- busy  output  1  a counted transfer is in progress.
- done  output  1  one-cycle pulse when a counted transfer completes.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on port reset. All state updates on the rising edge of clk.
- Reset (priority over everything): q=RST_VAL, cnt=0, busy=0, done=0. A reset during a transfer aborts it with no done pulse.
- en=0: q, cnt and busy hold; done is driven 0 on that edge.
- en=1, state changes:
  - mode 00: q holds.
  - mode 01: q <= {ser_in_msb, q[WIDTH-1:1]}.
  - mode 10: q <= {q[WIDTH-2:0], ser_in_lsb}.
  - mode 11: q <= d.
- Counter, width clog2(WIDTH)+1. FSM states: IDLE (busy=0) and XFER (busy=1).
  - Load (en=1, mode 11) in any state: cnt=0, go to XFER. A load during XFER restarts the count; no done pulse is generated for the abandoned transfer.
  - Shift (mode 01 or 10, en=1) in XFER with cnt<WIDTH-1: cnt increments.
  - Shift in XFER with cnt==WIDTH-1: cnt=0, done=1 on the same edge, go to IDLE. Right and left shifts may be mixed; both count.
  - Shifts in IDLE move q but do not count, and never raise done.
  - Hold in XFER: cnt holds, busy stays 1.
- done is registered and high for exactly one cycle after the WIDTH-th counted shift.
- Latency:
  - q reflects the operation one edge after it is sampled.
  - ser_out_* follow q with no extra delay.
- mode is a don't-care while en=0. An X on mode while en=1 is a verification error; the bench must assert against it.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: when rot=1, shifts rotate instead of using the serial inputs.
  - Shift right: q <= {q[0], q[WIDTH-1:1]}.
  - Shift left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Rotates count toward done exactly like shifts.
  - With rot=0, behaviour is identical to the base design.
- Undefined: the rot port is present but ignored; no rotate logic is synthesised.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5; apply reset=1 for one edge mid-stream -> q=8'hA5, busy=0, done=0 on the next cycle.
- Load then hold: en=1, mode=11, d=8'h3C, then mode=00 for 3 cycles -> q=8'h3C throughout, busy=1, done=0.
- Serial-out: load 8'h96, then 8 shift-right edges with ser_in_msb=0.
  - ser_out_lsb sequence is 0,1,1,0,1,0,0,1.
  - q=8'h00 after the 8th edge; done=1 for exactly one cycle; busy=0 afterwards.
- Enable gating: load 8'h01, shift left 4 edges, deassert en for 5 cycles, then shift left 4 more.
  - q=8'h10 during the stall; busy stays 1.
  - done pulses only after the 8th counted shift (q=8'h00 with ser_in_lsb=0).
- Restart and idle shifts:
  - Load 8'hFF, shift 5, reload 8'h0F, shift 8 -> exactly one done pulse, after the 8th post-reload shift.
  - 3 further shifts in IDLE -> no done.
- USR_ROTATE_EN defined: load 8'h81, rot=1, rotate left 1 -> q=8'h03; rotate right 2 -> q=8'hC0. With the macro undefined, the same stimulus with ser_in_lsb=0 and ser_in_msb=0 -> q=8'h02, then q=8'h00.
